// File: rtl/sram_bridge_pkg.sv
// Shared types, constants and byte-lane helpers for the 16-bit bus to
// 8-bit asynchronous SRAM bridge.
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    ACK    = 2'd3
  } state_t;

  // Width of the wait-state counter (supports 0..15 extra strobe cycles).
  localparam int WAIT_W = 4;

  // First lane to service: the even byte goes before the odd byte.
  function automatic logic first_lane(input logic [1:0] sel);
    return sel[0] ? 1'b0 : 1'b1;
  endfunction

  // Pick the write byte that belongs to a lane.
  function automatic logic [7:0] lane_byte(input logic [15:0] data, input logic lane);
    return lane ? data[15:8] : data[7:0];
  endfunction

  // Force unselected lanes of a read word to zero.
  function automatic logic [15:0] mask_lanes(input logic [15:0] data, input logic [1:0] sel);
    return {(sel[1] ? data[15:8] : 8'h00), (sel[0] ? data[7:0] : 8'h00)};
  endfunction

endpackage

// File: rtl/sram_bridge_if.sv
// CPU load/store bus: word-addressed request with byte lanes and a
// single-cycle acknowledge carrying read data.
interface sram_bridge_if;

  logic        m_access;
  logic [19:1] m_addr;
  logic        m_wr_en;
  logic [1:0]  m_bytesel;
  logic [15:0] m_wr_data;
  logic [15:0] m_rd_data;
  logic        m_ack;

  modport master (
    output m_access, m_addr, m_wr_en, m_bytesel, m_wr_data,
    input  m_rd_data, m_ack
  );

  modport slave (
    input  m_access, m_addr, m_wr_en, m_bytesel, m_wr_data,
    output m_rd_data, m_ack
  );

endinterface

// File: rtl/sram_bridge.sv
// Bus responder turning each 16-bit request into zero, one or two byte
// cycles on an 8-bit asynchronous SRAM. Every output is registered from
// the next-state values, so strobes are glitch-free and line up exactly
// with the state they belong to.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         srst,
  sram_bridge_if.slave bus,
  output logic [19:0]  s_addr,
  output logic [7:0]   s_data_out,
  output logic         s_data_oe,
  input  logic [7:0]   s_data_in,
  output logic         s_ce_n,
  output logic         s_oe_n,
  output logic         s_we_n
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_STATES);

  state_t              state_r, state_s;
  logic [19:1]         addr_r, addr_s;
  logic                wr_r, wr_s;
  logic [1:0]          sel_r, sel_s;
  logic [15:0]         wdata_r, wdata_s;
  logic                lane_r, lane_s;
  logic [WAIT_W-1:0]   wait_r, wait_s;
  logic [15:0]         rd_r, rd_s;

  logic                ack_r, ack_s;
  logic [15:0]         rd_data_r, rd_data_s;
  logic [19:0]         s_addr_s;
  logic [7:0]          s_data_out_s;
  logic                s_data_oe_s, s_ce_n_s, s_oe_n_s, s_we_n_s;

  assign bus.m_ack     = ack_r;
  assign bus.m_rd_data = rd_data_r;

  // Next-state, lane sequencing, wait counting and read-byte capture.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    wr_s    = wr_r;
    sel_s   = sel_r;
    wdata_s = wdata_r;
    lane_s  = lane_r;
    wait_s  = wait_r;
    rd_s    = rd_r;
    case (state_r)
      IDLE: begin
        if (bus.m_access) begin
          addr_s  = bus.m_addr;
          wr_s    = bus.m_wr_en;
          sel_s   = bus.m_bytesel;
          wdata_s = bus.m_wr_data;
          lane_s  = first_lane(bus.m_bytesel);
          wait_s  = {WAIT_W{1'b0}};
          if (!bus.m_wr_en) begin
            rd_s = 16'h0000;
          end else begin
            rd_s = rd_r;
          end
          if (bus.m_bytesel == 2'b00) begin
            state_s = ACK;
          end else begin
            state_s = SETUP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        wait_s  = {WAIT_W{1'b0}};
        state_s = STROBE;
      end
      STROBE: begin
        if (wait_r == WAIT_LAST) begin
          if (!wr_r) begin
            if (lane_r) begin
              rd_s[15:8] = s_data_in;
            end else begin
              rd_s[7:0] = s_data_in;
            end
          end else begin
            rd_s = rd_r;
          end
          if (!lane_r && sel_r[1]) begin
            lane_s  = 1'b1;
            state_s = SETUP;
          end else begin
            state_s = ACK;
          end
        end else begin
          wait_s = wait_r + 4'd1;
        end
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    ack_s        = 1'b0;
    rd_data_s    = rd_data_r;
    s_addr_s     = s_addr;
    s_data_out_s = s_data_out;
    s_data_oe_s  = 1'b0;
    s_ce_n_s     = 1'b1;
    s_oe_n_s     = 1'b1;
    s_we_n_s     = 1'b1;
    case (state_s)
      SETUP, STROBE: begin
        s_addr_s = {addr_s, lane_s};
        s_ce_n_s = 1'b0;
        if (wr_s) begin
          s_data_oe_s  = 1'b1;
          s_data_out_s = lane_byte(wdata_s, lane_s);
          s_we_n_s     = (state_s == STROBE) ? 1'b0 : 1'b1;
        end else begin
          s_oe_n_s = 1'b0;
        end
      end
      ACK: begin
        ack_s = 1'b1;
        if (wr_s) begin
          rd_data_s = 16'h0000;
        end else begin
          rd_data_s = mask_lanes(rd_s, sel_s);
        end
      end
      IDLE: begin
        ack_s = 1'b0;
      end
      default: begin
        ack_s = 1'b0;
      end
    endcase
  end

  // FSM state and transaction context registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      addr_r  <= 19'h00000;
      wr_r    <= 1'b0;
      sel_r   <= 2'b00;
      wdata_r <= 16'h0000;
      lane_r  <= 1'b0;
      wait_r  <= {WAIT_W{1'b0}};
      rd_r    <= 16'h0000;
    end else if (srst) begin
      state_r <= IDLE;
      addr_r  <= 19'h00000;
      wr_r    <= 1'b0;
      sel_r   <= 2'b00;
      wdata_r <= 16'h0000;
      lane_r  <= 1'b0;
      wait_r  <= {WAIT_W{1'b0}};
      rd_r    <= 16'h0000;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      wr_r    <= wr_s;
      sel_r   <= sel_s;
      wdata_r <= wdata_s;
      lane_r  <= lane_s;
      wait_r  <= wait_s;
      rd_r    <= rd_s;
    end
  end

  // Registered bus and SRAM pin outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_r      <= 1'b0;
      rd_data_r  <= 16'h0000;
      s_addr     <= 20'h00000;
      s_data_out <= 8'h00;
      s_data_oe  <= 1'b0;
      s_ce_n     <= 1'b1;
      s_oe_n     <= 1'b1;
      s_we_n     <= 1'b1;
    end else if (srst) begin
      ack_r      <= 1'b0;
      rd_data_r  <= 16'h0000;
      s_addr     <= 20'h00000;
      s_data_out <= 8'h00;
      s_data_oe  <= 1'b0;
      s_ce_n     <= 1'b1;
      s_oe_n     <= 1'b1;
      s_we_n     <= 1'b1;
    end else begin
      ack_r      <= ack_s;
      rd_data_r  <= rd_data_s;
      s_addr     <= s_addr_s;
      s_data_out <= s_data_out_s;
      s_data_oe  <= s_data_oe_s;
      s_ce_n     <= s_ce_n_s;
      s_oe_n     <= s_oe_n_s;
      s_we_n     <= s_we_n_s;
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Scoreboard bench for sram_bridge: three bridges (0, 1 and 15 wait
// states) share one behavioural SRAM; only one is driven at a time.
module tb_sram_bridge;

  typedef struct {
    int          inst;
    logic [15:0] data;
    int          ack_cyc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        srst;
  logic [2:0]  acc;
  logic [19:1] addr;
  logic        wr;
  logic [1:0]  sel;
  logic [15:0] wdata;

  logic [15:0] rdd   [3];
  logic [19:0] saddr [3];
  logic [7:0]  sdo   [3];
  logic [7:0]  sdi   [3];
  logic [2:0]  ack_v, sdoe, ce_n, oe_n, we_n;

  logic [7:0]  sram [0:16383];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        exp_q[$];
  int          ce_low [3] = '{0, 0, 0};
  int          we_low [3] = '{0, 0, 0};
  int          we_pul [3] = '{0, 0, 0};
  logic        we_prev [3] = '{1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 15);
    sram_bridge_if bus();
    assign bus.m_access  = acc[g];
    assign bus.m_addr    = addr;
    assign bus.m_wr_en   = wr;
    assign bus.m_bytesel = sel;
    assign bus.m_wr_data = wdata;
    assign rdd[g]        = bus.m_rd_data;
    assign ack_v[g]      = bus.m_ack;
    assign sdi[g] = (!ce_n[g] && !oe_n[g]) ? sram[saddr[g][13:0]] : 8'hEE;

    sram_bridge #(.WAIT_STATES(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .srst       (srst),
      .bus        (bus),
      .s_addr     (saddr[g]),
      .s_data_out (sdo[g]),
      .s_data_oe  (sdoe[g]),
      .s_data_in  (sdi[g]),
      .s_ce_n     (ce_n[g]),
      .s_oe_n     (oe_n[g]),
      .s_we_n     (we_n[g])
    );
  end

  // Behavioural SRAM: preload once, then accept bytes while CE and WE are low.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int k = 0; k < 16384; k++) sram[k] <= 8'h00;
      sram[14'h2468] <= 8'h34;
      sram[14'h2469] <= 8'h12;
      sram[14'h0003] <= 8'hA5;
      sram[14'h0002] <= 8'h5A;
    end else begin
      for (int g = 0; g < 3; g++)
        if (!ce_n[g] && !we_n[g]) sram[saddr[g][13:0]] <= sdo[g];
    end
  end

  function automatic int wst(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 15);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: strobe statistics and scoreboard pop on every acknowledge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!ce_n[g]) ce_low[g]++;
        if (!we_n[g]) we_low[g]++;
        if (!we_n[g] && we_prev[g]) we_pul[g]++;
        we_prev[g] = we_n[g];
        if (ack_v[g]) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ack: inst %0d acked at cycle %0d with nothing outstanding", g, cyc);
          end else begin
            e = exp_q.pop_front();
            check({e.name, " inst"}, g, e.inst);
            check({e.name, " ack_cycle"}, cyc, e.ack_cyc);
            check({e.name, " rd_data"}, {16'h0000, rdd[g]}, {16'h0000, e.data});
            check({e.name, " ack_pins"}, {28'h0, ce_n[g], oe_n[g], we_n[g], sdoe[g]}, 32'hE);
          end
        end
      end
    end
  end

  task automatic do_req(input int i, input logic [19:1] a, input logic w, input logic [1:0] s,
                        input logic [15:0] wd, input logic [15:0] erd, input string nm);
    exp_t e;
    bit   got;
    @(negedge clk);
    e.inst    = i;
    e.data    = erd;
    e.name    = nm;
    e.ack_cyc = cyc + 1 + (int'(s[0]) + int'(s[1])) * (2 + wst(i));
    exp_q.push_back(e);
    addr   = a;
    wr     = w;
    sel    = s;
    wdata  = wd;
    acc[i] = 1'b1;
    got    = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack_v[i]) begin
        got = 1'b1;
        break;
      end
    end
    acc[i] = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: no ack within 40 cycles", nm);
      exp_q.delete();
    end
  endtask

  initial begin
    int ce0, we0, wp0;
    bit seen;
    reset_n = 1'b0;
    srst    = 1'b0;
    acc     = 3'b000;
    addr    = 19'h00000;
    wr      = 1'b0;
    sel     = 2'b00;
    wdata   = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset ack", {31'h0, ack_v[1]}, 32'h0);
    check("reset rd_data", {16'h0, rdd[1]}, 32'h0);
    check("reset s_addr", {12'h0, saddr[1]}, 32'h0);
    check("reset s_data_out", {24'h0, sdo[1]}, 32'h0);
    check("reset pins", {28'h0, ce_n[1], oe_n[1], we_n[1], sdoe[1]}, 32'hE);
    reset_n = 1'b1;

    do_req(1, 19'h01234, 1'b0, 2'b11, 16'h0000, 16'h1234, "word_read");

    we0 = we_pul[1];
    do_req(1, 19'h00010, 1'b1, 2'b11, 16'hBEEF, 16'h0000, "word_write");
    check("word_write lo byte", {24'h0, sram[14'h0020]}, 32'hEF);
    check("word_write hi byte", {24'h0, sram[14'h0021]}, 32'hBE);
    check("word_write we pulses", we_pul[1] - we0, 2);

    do_req(1, 19'h00001, 1'b0, 2'b10, 16'h0000, 16'hA500, "odd_read");

    we0 = we_pul[1];
    do_req(1, 19'h00001, 1'b1, 2'b10, 16'h7700, 16'h0000, "odd_write");
    check("odd_write odd byte", {24'h0, sram[14'h0003]}, 32'h77);
    check("odd_write even byte kept", {24'h0, sram[14'h0002]}, 32'h5A);
    check("odd_write we pulses", we_pul[1] - we0, 1);

    ce0 = ce_low[1];
    do_req(1, 19'h00001, 1'b0, 2'b00, 16'h0000, 16'h0000, "sel00");
    check("sel00 ce activity", ce_low[1] - ce0, 0);
    do_req(1, 19'h00010, 1'b0, 2'b01, 16'h0000, 16'h00EF, "b2b_read");
    do_req(1, 19'h00001, 1'b0, 2'b11, 16'h0000, 16'h775A, "word_read2");
    repeat (3) @(negedge clk);
    check("rd_data held", {16'h0, rdd[1]}, 32'h775A);

    ce0 = ce_low[0];
    do_req(0, 19'h01234, 1'b0, 2'b01, 16'h0000, 16'h0034, "w0_read");
    check("w0_read ce width", ce_low[0] - ce0, 2);
    we0 = we_low[0];
    wp0 = we_pul[0];
    do_req(0, 19'h00018, 1'b1, 2'b01, 16'h0011, 16'h0000, "w0_write");
    check("w0_write we width", we_low[0] - we0, 1);
    check("w0_write we pulses", we_pul[0] - wp0, 1);
    check("w0_write byte", {24'h0, sram[14'h0030]}, 32'h11);

    ce0 = ce_low[2];
    do_req(2, 19'h01234, 1'b0, 2'b10, 16'h0000, 16'h1200, "w15_read");
    check("w15_read ce width", ce_low[2] - ce0, 17);
    we0 = we_low[2];
    do_req(2, 19'h00018, 1'b1, 2'b10, 16'h2200, 16'h0000, "w15_write");
    check("w15_write we width", we_low[2] - we0, 16);
    check("w15_write byte", {24'h0, sram[14'h0031]}, 32'h22);

    // Reset during the first write strobe of a word write.
    @(negedge clk);
    addr   = 19'h00020;
    wr     = 1'b1;
    sel    = 2'b11;
    wdata  = 16'hCAFE;
    acc[1] = 1'b1;
    seen   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!we_n[1]) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid we seen", {31'h0, seen}, 32'h1);
    reset_n = 1'b0;
    acc[1]  = 1'b0;
    #1;
    check("rst_mid pins", {28'h0, ce_n[1], oe_n[1], we_n[1], sdoe[1]}, 32'hE);
    check("rst_mid ack", {31'h0, ack_v[1]}, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    do_req(1, 19'h01234, 1'b0, 2'b11, 16'h0000, 16'h1234, "post_reset_read");

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sram_bridge.md
# sram_bridge

Memory-bus responder that services the CPU load/store unit's 16-bit word-addressed bus from an external 8-bit asynchronous SRAM. Each bus request becomes zero, one or two SRAM byte cycles with a configurable number of wait states. The bridge then returns one `m_ack` pulse and, for reads, the assembled word. It sits between the CPU memory bus (or the bus arbiter) and the board SRAM pins.

## Interface
- `WAIT_STATES`, default 1: extra strobe cycles per SRAM byte access. Legal range 0..15.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `m_access` input 1: bus request. Held high by the initiator until `m_ack`.
- `m_addr` input [19:1]: word address.
- `m_wr_en` input 1: 1 = write, 0 = read.
- `m_bytesel` input [1:0]: byte lanes. Bit 0 selects `[7:0]` (even byte); bit 1 selects `[15:8]` (odd byte).
- `m_wr_data` input 16: write data, lane-aligned.
- `m_rd_data` output 16: read data. Valid in the `m_ack` cycle and held until the next acknowledge.
- `m_ack` output 1: single-cycle completion pulse.
- `s_addr` output 20: SRAM byte address.
- `s_data_out` output 8: SRAM write data.
- `s_data_oe` output 1: drive enable for the SRAM data pins.
- `s_data_in` input 8: SRAM read data.
- `s_ce_n`, `s_oe_n`, `s_we_n` output 1 each: active-low SRAM strobes.

## Operation
- States: `IDLE`, `SETUP`, `STROBE`, `ACK`.
- **`IDLE`:**
  - When `m_access` is high, latch `m_addr`, `m_wr_en`, `m_bytesel` and `m_wr_data`.
  - Set the lane counter to the first selected lane (lane 0 before lane 1).
  - If `m_bytesel == 2'b00`, go straight to `ACK`. Otherwise go to `SETUP`.
- **`SETUP`** (1 cycle):
  - `s_addr = {addr_q, lane}` and `s_ce_n = 0`.
  - Read: `s_oe_n = 0`.
  - Write: `s_oe_n = 1`, `s_data_oe = 1`, `s_data_out` = selected lane, `s_we_n = 1`.
- **`STROBE`** (`WAIT_STATES+1` cycles, counted by a 4-bit wait counter):
  - Same outputs as `SETUP`, except `s_we_n = 0` for writes.
  - Read data: on the last `STROBE` cycle, capture `s_data_in` into the selected lane of `rd_q`.
  - After the last cycle, go to `SETUP` for lane 1 if it is still pending; otherwise go to `ACK`.
- **`ACK`** (1 cycle):
  - `m_ack = 1`; all strobes inactive.
  - `m_rd_data = rd_q`. Unselected lanes read as 0: `bytesel 01` gives `{8'h00, lo}`, `bytesel 10` gives `{hi, 8'h00}`.
  - Next state is `IDLE`.
- **Write between lanes:** `s_we_n` returns high in the lane-1 `SETUP` cycle, so every byte gets a distinct write pulse.
- **Read data clearing:** `rd_q` is cleared at acceptance of every read.
- **Writes:** `m_rd_data` is 0 in the `ACK` cycle of a write.
- **`m_access` during a transaction:** ignored outside `IDLE`. If it drops mid-transaction (a protocol violation), the transaction still completes and acknowledges.
- **Reset values** (asynchronous, immediate, including mid-transaction):
  - State returns to `IDLE`.
  - `m_ack = 0`, `m_rd_data = 0`, `s_addr = 0`, `s_data_out = 0`, `s_data_oe = 0`.
  - `s_ce_n`, `s_oe_n` and `s_we_n` all = 1.

## Timing
- Acceptance cycle is c (`IDLE` with `m_access` high).
- `m_ack` is asserted in cycle c + 1 + n·(2 + `WAIT_STATES`), where n = number of selected lanes (0, 1 or 2).
- Example, `WAIT_STATES = 1`: byte access acks at c+4; word access acks at c+7; `bytesel 00` acks at c+1.
- The bridge is back in `IDLE` the cycle after `ACK`. A new request seen then is accepted with no dead cycle.
- The initiator drops `m_access` during the `m_ack` cycle. The bridge never samples `m_access` in `ACK`, so there is no double accept.
- All SRAM outputs are registered (glitch-free strobes). `s_addr` and `s_data_out` are stable for the full `SETUP` + `STROBE` window of each byte.
- `s_data_oe` is 0 in `IDLE` and `ACK` for all transactions; it is high only during write `SETUP`/`STROBE`.

## Structure
- Package `sram_bridge_pkg`:
  - `typedef enum logic [1:0]` state type (`IDLE`, `SETUP`, `STROBE`, `ACK`).
  - `localparam` wait-counter width 4.
- Single module with no sub-module. FSM, wait counter and lane register are all local.

## Test plan
- **Word read, `WAIT_STATES = 1`:** SRAM[0x02468] = 0x34, [0x02469] = 0x12; request read `m_addr` = 0x01234, `bytesel 11` → reads at `s_addr` 0x02468 then 0x02469; `m_rd_data` = 0x1234; `m_ack` at c+7.
- **Word write 0xBEEF to `m_addr` 0x00010:** → two distinct `s_we_n` low pulses. 0xEF is written at 0x00020 and 0xBE at 0x00021. `s_we_n` is high in between. `m_ack` at c+7.
- **Odd-byte accesses:**
  - Read `bytesel 10` at `m_addr` 0x00001 with SRAM[0x00003] = 0xA5 → single cycle at 0x00003; `m_rd_data` = 0xA500; `m_ack` at c+4.
  - Write `bytesel 10` with data 0x7700 → only 0x77 written, at 0x00003.
- **`bytesel 00`:** → no `s_ce_n` activity; `m_ack` at c+1. Then a back-to-back read issued the cycle after ack is accepted immediately.
- **`WAIT_STATES = 0` and 15:** byte read → `m_ack` at c+3 and c+18 respectively; strobe widths are 1 and 16 cycles.
- **Reset mid-operation:** assert `reset_n` low during a word-write `STROBE` → strobes high and `s_data_oe` = 0 in the same cycle; no `m_ack`. After release, a fresh read completes normally.
